// File: rtl/lau_pkg.sv
// Arithmetic library shared types.
// Adder speed selection and multiply-add opcodes.
package lau_pkg;

  typedef enum logic {
    SLOW = 1'b0,
    FAST = 1'b1
  } speed_e;

  typedef enum logic [1:0] {
    MADD_OP = 2'd0,
    MAC_OP  = 2'd1,
    LOAD_OP = 2'd2
  } madd_op_e;

endpackage

// File: rtl/mul_pp_csa.sv
// Signed/unsigned partial products reduced to
// carry-save sum/carry vectors, modulo 2^WidthO.
module mul_pp_csa #(
  parameter int unsigned WidthX = 8,
  parameter int unsigned WidthY = 8,
  parameter int unsigned WidthO = WidthX + WidthY
) (
  input  logic              sgn_i,
  input  logic [WidthX-1:0] x_i,
  input  logic [WidthY-1:0] y_i,
  output logic [WidthO-1:0] sum_o,
  output logic [WidthO-1:0] carry_o
);

  logic [WidthO-1:0] w_yext;
  logic [WidthO-1:0] w_s;
  logic [WidthO-1:0] w_c;
  logic [WidthO-1:0] w_row;
  logic [WidthO-1:0] w_t;
  logic              w_neg;

  assign w_yext = {{(WidthO-WidthY){sgn_i & y_i[WidthY-1]}}, y_i};
  assign w_neg  = sgn_i & x_i[WidthX-1];

  // Signed X: top row has negative weight, so it is
  // added as ~row with a +1 correction row at the end.
  always_comb begin
    w_s   = '0;
    w_c   = '0;
    w_row = '0;
    w_t   = '0;
    for (int i = 0; i < WidthX; i++) begin
      w_row = x_i[i] ? (w_yext << i) : '0;
      if (i == WidthX - 1 && w_neg) begin
        w_row = ~w_row;
      end
      w_t = w_s ^ w_c ^ w_row;
      w_c = ((w_s & w_c) | (w_s & w_row) | (w_c & w_row)) << 1;
      w_s = w_t;
    end
    w_row = WidthO'(w_neg);
    w_t   = w_s ^ w_c ^ w_row;
    w_c   = ((w_s & w_c) | (w_s & w_row) | (w_c & w_row)) << 1;
    w_s   = w_t;
  end

  assign sum_o   = w_s;
  assign carry_o = w_c;

endmodule

// File: rtl/mul_add_pipe.sv
// Pipelined multiply-add / accumulate unit with
// valid/ready flow control and overflow flag.
module mul_add_pipe
  import lau_pkg::*;
#(
  parameter int unsigned WidthX    = 8,
  parameter int unsigned WidthY    = 8,
  parameter int unsigned WidthA    = 20,
  parameter speed_e      Speed     = FAST,
  parameter int unsigned NumStages = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  madd_op_e          op_i,
  input  logic              signed_i,
  input  logic [WidthX-1:0] X,
  input  logic [WidthY-1:0] Y,
  input  logic [WidthA-1:0] A,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WidthA-1:0] P,
  output logic              ovf_o
);

  typedef struct packed {
    logic [WidthA-1:0] s;
    logic [WidthA-1:0] c;
    logic [WidthA-1:0] a;
    madd_op_e          op;
    logic              sgn;
    logic              psgn;
  } st1_t;

  logic [WidthA-1:0] w_ps;
  logic [WidthA-1:0] w_pc;
  st1_t              w_s1_in;
  st1_t              w_s2;
  logic              w_s2_v;
  logic              w_ld1;
  logic              w_ld2;

  logic              r_v2;
  logic [WidthA-1:0] r_p;
  logic              r_ovf;
  logic [WidthA-1:0] r_acc;

  mul_pp_csa #(
    .WidthX(WidthX),
    .WidthY(WidthY),
    .WidthO(WidthA)
  ) u_pp (
    .sgn_i  (signed_i),
    .x_i    (X),
    .y_i    (Y),
    .sum_o  (w_ps),
    .carry_o(w_pc)
  );

  // Product sign is only consulted when the product
  // is nonzero; a zero product can never overflow.
  always_comb begin
    w_s1_in      = '0;
    w_s1_in.s    = w_ps;
    w_s1_in.c    = w_pc;
    w_s1_in.a    = A;
    w_s1_in.op   = op_i;
    w_s1_in.sgn  = signed_i;
    w_s1_in.psgn = signed_i & (X[WidthX-1] ^ Y[WidthY-1]);
  end

  assign w_ld2 = ~r_v2 | ready_i;

  if (NumStages == 2 && WidthX <= WidthY
      && WidthA >= WidthX + WidthY) begin : g_two
    logic r_v1;
    st1_t r_s1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_v1 <= 1'b0;
        r_s1 <= '0;
      end else if (w_ld1) begin
        r_v1 <= valid_i;
        if (valid_i) begin
          r_s1 <= w_s1_in;
        end
      end
    end

    assign w_ld1  = ~r_v1 | w_ld2;
    assign w_s2_v = r_v1;
    assign w_s2   = r_s1;
  end else if (NumStages == 1 && WidthX <= WidthY
      && WidthA >= WidthX + WidthY) begin : g_one
    assign w_ld1  = w_ld2;
    assign w_s2_v = valid_i;
    assign w_s2   = w_s1_in;
  end else begin : g_bad
    $error("mul_add_pipe: illegal NumStages or widths");
    assign w_ld1  = 1'b0;
    assign w_s2_v = 1'b0;
    assign w_s2   = '0;
  end

  logic              w_is_mac;
  logic              w_upd;
  logic [WidthA-1:0] w_add;
  logic [WidthA-1:0] w_cs;
  logic [WidthA-1:0] w_cc;
  logic [WidthA-1:0] w_p;
  logic              w_ovf;

  always_comb begin
    w_is_mac = 1'b0;
    w_upd    = 1'b0;
    unique case (1'b1)
      (w_s2.op == MAC_OP): begin
        w_is_mac = 1'b1;
        w_upd    = 1'b1;
      end
      (w_s2.op == LOAD_OP): w_upd = 1'b1;
      default: ;
    endcase
  end

  assign w_add = w_is_mac ? r_acc : w_s2.a;
  assign w_cs  = w_s2.s ^ w_s2.c ^ w_add;
  assign w_cc  = ((w_s2.s & w_s2.c)
                | (w_s2.s & w_add)
                | (w_s2.c & w_add)) << 1;

  if (Speed == FAST) begin : g_fast
    assign w_p = w_cs + w_cc;
  end else begin : g_slow
    logic w_rc;
    always_comb begin
      w_p  = '0;
      w_rc = 1'b0;
      for (int i = 0; i < int'(WidthA); i++) begin
        w_p[i] = w_cs[i] ^ w_cc[i] ^ w_rc;
        w_rc   = (w_cs[i] & w_cc[i])
               | (w_cs[i] & w_rc)
               | (w_cc[i] & w_rc);
      end
    end
  end

  // Product fits in WidthA, so an unsigned wrap shows
  // up as a result smaller than the addend.
  assign w_ovf = w_s2.sgn
    ? ((w_s2.psgn == w_add[WidthA-1])
       && (w_p[WidthA-1] != w_add[WidthA-1]))
    : (w_p < w_add);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v2  <= 1'b0;
      r_p   <= '0;
      r_ovf <= 1'b0;
      r_acc <= '0;
    end else if (w_ld2) begin
      r_v2 <= w_s2_v;
      if (w_s2_v) begin
        r_p   <= w_p;
        r_ovf <= w_ovf;
        if (w_upd) begin
          r_acc <= w_p;
        end
      end
    end
  end

  assign ready_o = w_ld1;
  assign valid_o = r_v2;
  assign P       = r_p;
  assign ovf_o   = r_ovf;

endmodule

// File: doc/mul_add_pipe.md
Name: mul_add_pipe

Overview:
- Pipelined multiply-add/accumulate unit: P = X*Y + A, or P = X*Y + acc.
- Selectable signed/unsigned operands, 1- or 2-stage pipeline, valid/ready handshake on both sides, per-result overflow flag.
- Built for datapaths (filters, dot products) that need one MAC per cycle with backpressure.
- Uses the carry-save/final-adder style of the arithmetic library.

Parameters:
- WidthX, 8, width of multiplier X (<= WidthY).
- WidthY, 8, width of multiplicand Y.
- WidthA, 20, width of A, P and the accumulator (>= WidthX+WidthY).
- Speed, lau_pkg::FAST, performance parameter passed to the final adder.
- NumStages, 2, pipeline depth, 1 or 2; any other value is an elaboration error.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  input operation valid.
- ready_o  out  1  unit accepts an operation this cycle.
- op_i  in  lau_pkg::madd_op_e  MADD / MAC / LOAD.
- signed_i  in  1  1 = two's-complement X, Y, A; 0 = unsigned.
- X  in  WidthX  multiplier.
- Y  in  WidthY  multiplicand.
- A  in  WidthA  augend (ignored for MAC).
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- P  out  WidthA  result.
- ovf_o  out  1  true result does not fit in WidthA bits under signed_i.

Behaviour:
- Reset (async, rst_ni=0):
  - All stage valid bits 0, so valid_o=0.
  - P=0, ovf_o=0, accumulator acc_q=0.
  - ready_o=1 from the first cycle after release.
  - Reset mid-operation discards all in-flight operations.
- Operations:
  - MADD: P = X*Y + A; acc_q unchanged.
  - MAC: P = X*Y + acc_q; acc_q <= P.
  - LOAD: P = X*Y + A; acc_q <= P.
- Arithmetic:
  - Product is formed full width (WidthX+WidthY), zero- or sign-extended per signed_i to WidthA, then added modulo 2^WidthA.
  - ovf_o (unsigned): carry out of bit WidthA-1.
  - ovf_o (signed): exact sum outside [-2^(WidthA-1), 2^(WidthA-1)-1].
  - In MAC, the accumulator is interpreted with the signed_i of the current operation.
- Pipeline, NumStages=2:
  - Stage 1 registers the carry-save sum/carry of the partial products plus op, signed_i, A.
  - Stage 2 performs the 3:2 compression with A or acc_q, the final carry-propagate add and overflow detection, and registers P/ovf_o.
- Pipeline, NumStages=1: everything is combinational into the output register.
- Latency: valid_o rises NumStages cycles after the input handshake (valid_i & ready_o).
- Throughput: one operation per cycle, including back-to-back MACs.
  - The accumulator is consumed only in the last stage and is updated on the same edge that loads P, so no hazard exists.
- Flow control:
  - Stage k loads when it is empty or stage k+1 loads; the last stage loads when it is empty or ready_i=1.
  - ready_o = load enable of stage 1. The combinational ready_i -> ready_o path is permitted.
  - Capacity is NumStages operations.
- Stall: with valid_o=1 and ready_i=0, P, ovf_o and acc_q hold stable and all full stages hold.
- Ordering: results leave strictly in acceptance order.
- Simultaneous events: output transfer and a new input accept in the same cycle are both honoured.
- valid_i=0 never updates acc_q.

Decomposition:
- lau_pkg gains `typedef enum logic [1:0] {MADD_OP=0, MAC_OP=1, LOAD_OP=2} madd_op_e`; value 3 behaves as MADD.
- Sub-module mul_pp_csa: signed/unsigned partial-product generation plus carry-save reduction to sum/carry vectors. It is purely combinational and parameterised by WidthX, WidthY.
- The top level holds the pipeline registers, the accumulator, the final adder and the overflow logic.

Test Plan (WidthX=WidthY=8, WidthA=20, NumStages=2):
- Unsigned MADD, X=0xFF, Y=0xFF, A=1:
  - P=0x0FE02, ovf_o=0.
  - valid_o high exactly 2 cycles after accept.
- Signed MADD, X=0xFF (-1), Y=0x02, A=0:
  - P=0xFFFFE, ovf_o=0.
- Accumulate chain on consecutive cycles: LOAD X=3,Y=4,A=10; MAC X=2,Y=5; MAC X=1,Y=1:
  - P=22, 32, 33 on three consecutive valid_o cycles.
- Backpressure: hold ready_i=0 and offer 3 MACs from acc=0, each X=1, Y=1:
  - ready_o drops after 2 accepts.
  - After ready_i=1, P=1, 2, 3 in order.
  - No double accumulator update.
- Overflow, unsigned: A=0xFFFFF, X=1, Y=1 -> P=0, ovf_o=1.
- Overflow, signed: A=0x7FFFF, X=1, Y=1 -> P=0x80000, ovf_o=1.
- Reset mid-flight:
  - Pull rst_ni low with 2 operations in flight -> valid_o=0 immediately.
  - After release, MAC X=1, Y=1 -> P=1 (accumulator cleared).
